// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the Moroso multi-lane register file.
package regfile_pkg;

    localparam int unsigned NLANES_DEF = 4;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NPREDS_DEF = 3;

    // Upper bound on lanes the priority helper can arbitrate between.
    localparam int unsigned MAX_LANES  = 16;
    localparam int unsigned LANE_IDX_W = 4;

    typedef struct packed {
        logic                  hit;
        logic [LANE_IDX_W-1:0] lane;
    } lane_sel_t;

    // Register index width for a power-of-two register count.
    function automatic int unsigned rw_of(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    // Lowest-numbered set bit wins; shared by the write and bypass paths.
    function automatic lane_sel_t first_lane(input logic [MAX_LANES-1:0] match);
        lane_sel_t sel;
        sel = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (match[i] && !sel.hit) begin
                sel.hit  = 1'b1;
                sel.lane = LANE_IDX_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per GPR plus busy lookup for all read ports.
// Optional macro REGFILE_BYPASS_EN: a same-cycle GPR writeback hides the busy bit
// instead of extending it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NLANES = NLANES_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    localparam int unsigned RW     = rw_of(NREGS)
) (
    input  logic                 clkrst_core_clk,
    input  logic                 clkrst_core_rst,
    input  logic [NLANES-1:0]    claim,
    input  logic [NLANES*RW-1:0] claim_num,
    input  logic [NLANES*RW-1:0] wb_num,
    input  logic [NLANES-1:0]    wb_any,
    input  logic [NLANES-1:0]    wb_data_we,
    input  logic [NLANES*RW-1:0] rs_num,
    input  logic [NLANES*RW-1:0] rt_num,
    output logic [NLANES-1:0]    rs_busy,
    output logic [NLANES-1:0]    rt_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    function automatic logic port_busy(input logic [RW-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int unsigned l = 0; l < NLANES; l++) begin
`ifdef REGFILE_BYPASS_EN
            if (wb_data_we[l] && wb_num[l*RW +: RW] == a) hit = 1'b1;
`else
            if (wb_any[l] && wb_num[l*RW +: RW] == a) hit = 1'b1;
`endif
        end
        if (clkrst_core_rst || a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        return busy_q[a] && !hit;
`else
        return busy_q[a] || hit;
`endif
    endfunction

    // Next busy vector: clears applied before claims so a same-cycle claim wins
    always_comb begin
        busy_d = busy_q;
        for (int unsigned l = 0; l < NLANES; l++) begin
            if (wb_any[l]) busy_d[wb_num[l*RW +: RW]] = 1'b0;
        end
        for (int unsigned l = 0; l < NLANES; l++) begin
            if (claim[l]) busy_d[claim_num[l*RW +: RW]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register with asynchronous clear
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) busy_q <= '0;
        else                 busy_q <= busy_d;
    end

    // Combinational busy lookup for every read port
    always_comb begin
        rs_busy = '0;
        rt_busy = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
            rs_busy[l] = port_busy(rs_num[l*RW +: RW]);
            rt_busy[l] = port_busy(rt_num[l*RW +: RW]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-lane GPR file with predicate bank and pending-write scoreboard.
// clkrst_core_rst is the asynchronous active-high core reset.
// Optional macro REGFILE_BYPASS_EN: reads return same-cycle writeback data
// (lowest lane wins), predicates likewise.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned NLANES = NLANES_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned NPREDS = NPREDS_DEF,
    localparam int unsigned RW     = rw_of(NREGS)
) (
    input  logic                     clkrst_core_clk,
    input  logic                     clkrst_core_rst,
    input  logic [NLANES*RW-1:0]     wb2rf_rd_num,
    input  logic [NLANES*DATA_W-1:0] wb2rf_rd_data,
    input  logic [NLANES-1:0]        wb2rf_rd_we,
    input  logic [NLANES-1:0]        wb2rf_pred_we,
    input  logic [NLANES*RW-1:0]     d2rf_rs_num,
    input  logic [NLANES*RW-1:0]     d2rf_rt_num,
    output logic [NLANES*DATA_W-1:0] rf2d_rs_data,
    output logic [NLANES*DATA_W-1:0] rf2d_rt_data,
    input  logic [NLANES-1:0]        d2rf_claim,
    input  logic [NLANES*RW-1:0]     d2rf_claim_num,
    output logic [NLANES-1:0]        rf2d_rs_busy,
    output logic [NLANES-1:0]        rf2d_rt_busy,
    output logic [NPREDS-1:0]        preds
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NPREDS-1:0] preds_q;
    logic [NPREDS-1:0] preds_d;
    logic [NLANES-1:0] wb_any;

    assign wb_any = wb2rf_rd_we | wb2rf_pred_we;

    // Next GPR contents: lowest-numbered writing lane wins, r0 stays zero
    always_comb begin
        logic [MAX_LANES-1:0] match;
        lane_sel_t            sel;
        int unsigned          li;
        for (int unsigned r = 0; r < NREGS; r++) begin
            match = '0;
            for (int unsigned l = 0; l < NLANES; l++) begin
                match[l] = wb2rf_rd_we[l] && (wb2rf_rd_num[l*RW +: RW] == RW'(r));
            end
            sel       = first_lane(match);
            li        = 32'(sel.lane);
            regs_d[r] = regs_q[r];
            if (r != 0 && sel.hit) regs_d[r] = wb2rf_rd_data[li*DATA_W +: DATA_W];
        end
    end

    // Next predicate bank: index is rd_num[1:0], data is bit 0, lowest lane wins
    always_comb begin
        logic [MAX_LANES-1:0] match;
        lane_sel_t            sel;
        int unsigned          li;
        preds_d = preds_q;
        for (int unsigned p = 0; p < NPREDS; p++) begin
            match = '0;
            for (int unsigned l = 0; l < NLANES; l++) begin
                match[l] = wb2rf_pred_we[l] && (wb2rf_rd_num[l*RW +: 2] == 2'(p));
            end
            sel = first_lane(match);
            li  = 32'(sel.lane);
            if (sel.hit) preds_d[p] = wb2rf_rd_data[li*DATA_W];
        end
    end

    // Storage with asynchronous clear
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
            preds_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
            preds_q <= preds_d;
        end
    end

    // Read ports; the bypass view is simply next-state, masked while in reset
    always_comb begin
        rf2d_rs_data = '0;
        rf2d_rt_data = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
`ifdef REGFILE_BYPASS_EN
            if (!clkrst_core_rst) begin
                rf2d_rs_data[l*DATA_W +: DATA_W] = regs_d[d2rf_rs_num[l*RW +: RW]];
                rf2d_rt_data[l*DATA_W +: DATA_W] = regs_d[d2rf_rt_num[l*RW +: RW]];
            end
`else
            rf2d_rs_data[l*DATA_W +: DATA_W] = regs_q[d2rf_rs_num[l*RW +: RW]];
            rf2d_rt_data[l*DATA_W +: DATA_W] = regs_q[d2rf_rt_num[l*RW +: RW]];
`endif
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign preds = clkrst_core_rst ? '0 : preds_d;
`else
    assign preds = preds_q;
`endif

    regfile_scoreboard #(
        .NLANES (NLANES),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .claim           (d2rf_claim),
        .claim_num       (d2rf_claim_num),
        .wb_num          (wb2rf_rd_num),
        .wb_any          (wb_any),
        .wb_data_we      (wb2rf_rd_we),
        .rs_num          (d2rf_rs_num),
        .rt_num          (d2rf_rt_num),
        .rs_busy         (rf2d_rs_busy),
        .rt_busy         (rf2d_rt_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver pushes expected outputs computed
// from an array-based model; a monitor pops and compares just before each edge.
module tb_regfile_mp;

    localparam int NL = 4;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int NP = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NL*RW-1:0] wb_num, rs_num, rt_num, claim_num;
    logic [NL*DW-1:0] wb_data, rs_data, rt_data;
    logic [NL-1:0]    wb_we, wb_pwe, claim, rs_busy, rt_busy;
    logic [NP-1:0]    preds;

    regfile_mp #(.NLANES(NL), .NREGS(32), .DATA_W(DW), .NPREDS(NP)) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .wb2rf_rd_num    (wb_num),
        .wb2rf_rd_data   (wb_data),
        .wb2rf_rd_we     (wb_we),
        .wb2rf_pred_we   (wb_pwe),
        .d2rf_rs_num     (rs_num),
        .d2rf_rt_num     (rt_num),
        .rf2d_rs_data    (rs_data),
        .rf2d_rt_data    (rt_data),
        .d2rf_claim      (claim),
        .d2rf_claim_num  (claim_num),
        .rf2d_rs_busy    (rs_busy),
        .rf2d_rt_busy    (rt_busy),
        .preds           (preds)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL*DW-1:0] rs;
        logic [NL*DW-1:0] rt;
        logic [NL-1:0]    rsb;
        logic [NL-1:0]    rtb;
        logic [NP-1:0]    pr;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [NP-1:0] m_preds;

    task automatic chk(input string name, input logic [NL*DW-1:0] got, input logic [NL*DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        logic [31:0] v;
        logic        found;
        v = m_regs[a];
        found = 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int l = 0; l < NL; l++) begin
            if (!found && a != 5'd0 && wb_we[l] && wb_num[l*RW +: RW] == a) begin
                v = wb_data[l*DW +: DW];
                found = 1'b1;
            end
        end
`endif
        if (rst) v = '0;
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic hit_we, hit_any;
        hit_we = 1'b0;
        hit_any = 1'b0;
        for (int l = 0; l < NL; l++) begin
            if (wb_num[l*RW +: RW] == a) begin
                if (wb_we[l]) hit_we = 1'b1;
                if (wb_we[l] || wb_pwe[l]) hit_any = 1'b1;
            end
        end
        if (rst || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        return m_busy[a] && !hit_we;
`else
        return m_busy[a] || hit_any;
`endif
    endfunction

    function automatic logic [NP-1:0] exp_preds();
        logic [NP-1:0] p;
        logic          found;
        p = m_preds;
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NP; i++) begin
            found = 1'b0;
            for (int l = 0; l < NL; l++) begin
                if (!found && wb_pwe[l] && wb_num[l*RW +: 2] == 2'(i)) begin
                    p[i] = wb_data[l*DW];
                    found = 1'b1;
                end
            end
        end
`endif
        if (rst) p = '0;
        return p;
    endfunction

    // Model state change at a clock edge (or reset)
    task automatic model_edge();
        logic [4:0] a;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            m_preds = '0;
        end else begin
            for (int l = NL - 1; l >= 0; l--) begin
                a = wb_num[l*RW +: RW];
                if (wb_we[l] && a != 5'd0) m_regs[a] = wb_data[l*DW +: DW];
                if (wb_pwe[l] && a[1:0] < 2'(NP)) m_preds[a[1:0]] = wb_data[l*DW];
            end
            for (int l = 0; l < NL; l++) begin
                a = wb_num[l*RW +: RW];
                if (wb_we[l] || wb_pwe[l]) m_busy[a] = 1'b0;
            end
            for (int l = 0; l < NL; l++) begin
                a = claim_num[l*RW +: RW];
                if (claim[l] && a != 5'd0) m_busy[a] = 1'b1;
            end
        end
    endtask

    // Inputs are already applied at a negedge: log expectation, cross the edge
    task automatic step();
        exp_t e;
        e = '0;
        for (int l = 0; l < NL; l++) begin
            e.rs[l*DW +: DW] = exp_data(rs_num[l*RW +: RW]);
            e.rt[l*DW +: DW] = exp_data(rt_num[l*RW +: RW]);
            e.rsb[l] = exp_busy(rs_num[l*RW +: RW]);
            e.rtb[l] = exp_busy(rt_num[l*RW +: RW]);
        end
        e.pr = exp_preds();
        q.push_back(e);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        wb_num = '0; wb_data = '0; wb_we = '0; wb_pwe = '0;
        rs_num = '0; rt_num = '0; claim = '0; claim_num = '0;
    endtask

    task automatic wb(input int l, input logic [4:0] n, input logic [31:0] d,
                      input logic we, input logic pwe);
        wb_num[l*RW +: RW] = n;
        wb_data[l*DW +: DW] = d;
        wb_we[l] = we;
        wb_pwe[l] = pwe;
    endtask

    task automatic rd(input int l, input logic [4:0] s, input logic [4:0] t);
        rs_num[l*RW +: RW] = s;
        rt_num[l*RW +: RW] = t;
    endtask

    function automatic logic [4:0] ra();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic rand_in();
        idle();
        for (int l = 0; l < NL; l++) begin
            wb(l, ra(), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            rd(l, ra(), ra());
            claim[l] = ($urandom_range(0, 3) == 0);
            claim_num[l*RW +: RW] = ra();
        end
    endtask

    // Monitor: compares one queued expectation just before each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rs_data", rs_data, e.rs);
                chk("rt_data", rt_data, e.rt);
                chk("rs_busy", {{(NL*DW-NL){1'b0}}, rs_busy}, {{(NL*DW-NL){1'b0}}, e.rsb});
                chk("rt_busy", {{(NL*DW-NL){1'b0}}, rt_busy}, {{(NL*DW-NL){1'b0}}, e.rtb});
                chk("preds", {{(NL*DW-NP){1'b0}}, preds}, {{(NL*DW-NP){1'b0}}, e.pr});
            end
        end
    end

    // Driver
    initial begin
        idle();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_preds = '0;
        @(negedge clk);
        // reset: traffic during reset is discarded, outputs all zero
        for (int c = 0; c < 2; c++) begin rand_in(); step(); end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            idle();
            for (int p = 0; p < NL; p++) rd(p, 5'(((c*8 + p) % 31) + 1), 5'(((c*8 + 4 + p) % 31) + 1));
            step();
        end
        // lane0 and lane3 collide on r5
        idle(); wb(0, 5'd5, 32'hAAAA0000, 1'b1, 1'b0); wb(3, 5'd5, 32'h5555FFFF, 1'b1, 1'b0); rd(0, 5'd5, 5'd5); step();
        idle(); rd(0, 5'd5, 5'd5); step();
        // r0 write and claim are ignored
        idle(); wb(0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0); claim[0] = 1'b1; rd(1, 5'd0, 5'd0); step();
        idle(); rd(0, 5'd0, 5'd0); step();
        // claim r7, writeback three cycles later
        idle(); claim[1] = 1'b1; claim_num[1*RW +: RW] = 5'd7; step();
        for (int c = 0; c < 3; c++) begin idle(); rd(1, 5'd7, 5'd7); step(); end
        idle(); wb(2, 5'd7, 32'h12, 1'b1, 1'b0); rd(1, 5'd7, 5'd7); step();
        idle(); rd(1, 5'd7, 5'd7); step();
        // same-cycle claim and writeback of r9: claim wins
        idle(); wb(0, 5'd9, 32'h99, 1'b1, 1'b0); claim[2] = 1'b1; claim_num[2*RW +: RW] = 5'd9; rd(3, 5'd9, 5'd9); step();
        idle(); rd(3, 5'd9, 5'd9); step();
        // write-to-read in the same cycle on r4
        idle(); wb(1, 5'd4, 32'h1111, 1'b1, 1'b0); step();
        idle(); wb(3, 5'd4, 32'hDEAD, 1'b1, 1'b0); rd(2, 5'd4, 5'd4); step();
        idle(); rd(2, 5'd4, 5'd4); step();
        // predicate collision: lane1 wins on pred 1
        idle(); wb(1, 5'd1, 32'h1, 1'b0, 1'b1); wb(2, 5'd1, 32'h0, 1'b0, 1'b1); step();
        idle(); step();
        // random traffic with a mid-run reset
        for (int c = 0; c < 300; c++) begin
            rst = (c == 150 || c == 151);
            rand_in();
            step();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #6;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
